// File: rtl/signal_chk_pkg.sv
// -----------------------------------------------------------------------------
// signal_chk_pkg
//
// Purpose : Shared definitions for the Avalon-ST ramp checker: CSR word
//           addresses, CONTROL/STATUS bit positions, the checker FSM state
//           type and the ramp successor helper.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package signal_chk_pkg;

    // CSR word addresses.
    localparam logic [2:0] ADDR_CONTROL      = 3'd0;
    localparam logic [2:0] ADDR_STATUS       = 3'd1;
    localparam logic [2:0] ADDR_BEAT_COUNT   = 3'd2;
    localparam logic [2:0] ADDR_ERROR_COUNT  = 3'd3;
    localparam logic [2:0] ADDR_WRAP_COUNT   = 3'd4;
    localparam logic [2:0] ADDR_LAST_ERR_RX  = 3'd5;
    localparam logic [2:0] ADDR_LAST_ERR_EXP = 3'd6;

    // CONTROL bit positions.
    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_CLEAR_BIT  = 1;

    // STATUS bit positions (state occupies two bits starting at the LSB given).
    localparam int STAT_LOCKED_BIT = 0;
    localparam int STAT_STICKY_BIT = 1;
    localparam int STAT_STATE_LSB  = 2;

    // Checker FSM states; the encoding is visible through STATUS.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_TRACK = 2'd2
    } chk_state_e;

    // Value that must follow d in the ramp, wrapping from end_v to start_v.
    function automatic logic [31:0] ramp_next(input logic [31:0] d,
                                              input logic [31:0] start_v,
                                              input logic [31:0] end_v);
        return (d == end_v) ? start_v : (d + 32'd1);
    endfunction

endpackage

// File: rtl/sat_counter32.sv
// -----------------------------------------------------------------------------
// sat_counter32
//
// Purpose : 32-bit event counter that sticks at 0xFFFFFFFF instead of wrapping.
// Ports   : clk      - clock
//           reset_n  - synchronous active-low reset (count -> 0)
//           i_clear  - synchronous clear, wins over i_inc
//           i_inc    - count one event this cycle
//           o_count  - current count
// -----------------------------------------------------------------------------
module sat_counter32 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_clear,
    input  logic        i_inc,
    output logic [31:0] o_count
);

    logic [31:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != 32'hFFFF_FFFF)) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/signal_checker.sv
// -----------------------------------------------------------------------------
// signal_checker
//
// Purpose : Avalon-ST sink that locks onto an incrementing ramp
//           (START_VALUE..END_VALUE, wrapping) and checks every accepted beat,
//           counting beats, wraps and errors. Results and control live in a
//           small Avalon-MM CSR slave. Optional periodic backpressure drops
//           ready for one cycle in every STALL_PERIOD cycles.
//
// Handshake: a beat transfers on a rising edge where valid=1 and ready=1
//            (readyLatency 0). ready is derived from registers only, so it
//            never depends on valid/data in the same cycle. Data on any other
//            cycle is ignored.
//
// Ports   : clk                  - single clock
//           reset_n              - synchronous active-low reset
//           avalonst_sink_valid  - source beat valid
//           avalonst_sink_data   - source beat data (32 bit)
//           avalonst_sink_ready  - sink ready
//           avalonmm_address     - CSR word address (3 bit)
//           avalonmm_read        - CSR read strobe, readdata valid next cycle
//           avalonmm_readdata    - CSR read data, held until the next read
//           avalonmm_write       - CSR write strobe
//           avalonmm_writedata   - CSR write data
// -----------------------------------------------------------------------------
module signal_checker
    import signal_chk_pkg::*;
#(
    parameter logic [31:0] START_VALUE  = 32'd0,
    parameter logic [31:0] END_VALUE    = 32'd255,
    parameter int unsigned STALL_PERIOD = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        avalonst_sink_valid,
    input  logic [31:0] avalonst_sink_data,
    output logic        avalonst_sink_ready,
    input  logic [2:0]  avalonmm_address,
    input  logic        avalonmm_read,
    output logic [31:0] avalonmm_readdata,
    input  logic        avalonmm_write,
    input  logic [31:0] avalonmm_writedata
);

    // Last value of the free-running stall counter; unused when STALL_PERIOD=0.
    localparam logic [31:0] STALL_LAST =
        (STALL_PERIOD == 0) ? 32'd0 : 32'(STALL_PERIOD - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    chk_state_e  r_state;
    logic        r_enable;
    logic        r_locked;
    logic        r_sticky;
    logic [31:0] r_expected;
    logic [31:0] r_err_rx;
    logic [31:0] r_err_exp;
    logic [31:0] r_stall_cnt;
    logic [31:0] r_readdata;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    chk_state_e  w_state_next;
    logic        w_enable_next;
    logic        w_locked_next;
    logic        w_sticky_next;
    logic [31:0] w_expected_next;
    logic [31:0] w_err_rx_next;
    logic [31:0] w_err_exp_next;

    logic        w_ready;
    logic        w_stall_slot;
    logic        w_beat;
    logic        w_in_range;
    logic        w_ctrl_wr;
    logic        w_clear;
    logic        w_beat_inc;
    logic        w_err_inc;
    logic        w_wrap_inc;
    logic [31:0] w_beat_count;
    logic [31:0] w_err_count;
    logic [31:0] w_wrap_count;
    logic [31:0] w_status;
    logic [31:0] w_rd_mux;
    logic        w_unused_wdata;

    // Upper CONTROL write bits carry nothing.
    assign w_unused_wdata = ^avalonmm_writedata[31:2];

    // ------------------------------------------------------------------
    // Backpressure and handshake
    // ------------------------------------------------------------------
    assign w_stall_slot = (STALL_PERIOD != 0) && (r_stall_cnt == STALL_LAST);
    assign w_ready      = r_enable && !w_stall_slot;
    assign w_beat       = avalonst_sink_valid && w_ready;

    assign avalonst_sink_ready = w_ready;

    // Range test as a single unsigned compare: values below START_VALUE
    // wrap to huge offsets and fail the bound, so no separate lower check.
    assign w_in_range = ((avalonst_sink_data - START_VALUE) <= (END_VALUE - START_VALUE));

    assign w_ctrl_wr = avalonmm_write && (avalonmm_address == ADDR_CONTROL);
    assign w_clear   = w_ctrl_wr && avalonmm_writedata[CTRL_CLEAR_BIT];

    // ------------------------------------------------------------------
    // FSM: next state and datapath updates
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_enable_next   = r_enable;
        w_locked_next   = r_locked;
        w_sticky_next   = r_sticky;
        w_expected_next = r_expected;
        w_err_rx_next   = r_err_rx;
        w_err_exp_next  = r_err_exp;
        w_beat_inc      = 1'b0;
        w_err_inc       = 1'b0;
        w_wrap_inc      = 1'b0;

        if (w_ctrl_wr) begin
            w_enable_next = avalonmm_writedata[CTRL_ENABLE_BIT];
        end

        if (w_clear) begin
            // Clear beats a simultaneous beat: that beat is dropped entirely.
            w_sticky_next   = 1'b0;
            w_err_rx_next   = '0;
            w_err_exp_next  = '0;
            w_locked_next   = 1'b0;
            w_expected_next = START_VALUE;
            w_state_next    = w_enable_next ? ST_SYNC : ST_IDLE;
        end else if (w_ctrl_wr && !avalonmm_writedata[CTRL_ENABLE_BIT]) begin
            // Disabling also drops a beat arriving in the same cycle.
            w_state_next  = ST_IDLE;
            w_locked_next = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Only an enable=1 write reaches here.
                    if (w_ctrl_wr) begin
                        w_state_next = ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (w_beat) begin
                        w_beat_inc = 1'b1;
                        if (w_in_range) begin
                            w_expected_next = ramp_next(avalonst_sink_data, START_VALUE, END_VALUE);
                            w_locked_next   = 1'b1;
                            w_state_next    = ST_TRACK;
                        end else begin
                            w_err_inc = 1'b1;
                        end
                    end
                end
                ST_TRACK: begin
                    if (w_beat) begin
                        w_beat_inc = 1'b1;
                        if (avalonst_sink_data == r_expected) begin
                            w_wrap_inc = (avalonst_sink_data == END_VALUE);
                        end else begin
                            w_err_inc      = 1'b1;
                            w_sticky_next  = 1'b1;
                            w_err_rx_next  = avalonst_sink_data;
                            w_err_exp_next = r_expected;
                        end
                        // Matched or not, follow the received value (resync).
                        w_expected_next = ramp_next(avalonst_sink_data, START_VALUE, END_VALUE);
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_enable   <= 1'b0;
            r_locked   <= 1'b0;
            r_sticky   <= 1'b0;
            r_expected <= START_VALUE;
            r_err_rx   <= '0;
            r_err_exp  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_enable   <= w_enable_next;
            r_locked   <= w_locked_next;
            r_sticky   <= w_sticky_next;
            r_expected <= w_expected_next;
            r_err_rx   <= w_err_rx_next;
            r_err_exp  <= w_err_exp_next;
        end
    end

    // Free-running stall counter, independent of enable.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
        end else if (STALL_PERIOD == 0) begin
            r_stall_cnt <= '0;
        end else if (r_stall_cnt == STALL_LAST) begin
            r_stall_cnt <= '0;
        end else begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    sat_counter32 u_beat_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clear (w_clear),
        .i_inc   (w_beat_inc),
        .o_count (w_beat_count)
    );

    sat_counter32 u_err_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clear (w_clear),
        .i_inc   (w_err_inc),
        .o_count (w_err_count)
    );

    sat_counter32 u_wrap_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clear (w_clear),
        .i_inc   (w_wrap_inc),
        .o_count (w_wrap_count)
    );

    // ------------------------------------------------------------------
    // CSR read path. Registered, so a read coinciding with an update
    // returns the value from before the update.
    // ------------------------------------------------------------------
    always_comb begin
        w_status                                 = '0;
        w_status[STAT_LOCKED_BIT]                = r_locked;
        w_status[STAT_STICKY_BIT]                = r_sticky;
        w_status[STAT_STATE_LSB +: 2]            = r_state;

        w_rd_mux = '0;
        case (avalonmm_address)
            ADDR_CONTROL:      w_rd_mux = {31'd0, r_enable};
            ADDR_STATUS:       w_rd_mux = w_status;
            ADDR_BEAT_COUNT:   w_rd_mux = w_beat_count;
            ADDR_ERROR_COUNT:  w_rd_mux = w_err_count;
            ADDR_WRAP_COUNT:   w_rd_mux = w_wrap_count;
            ADDR_LAST_ERR_RX:  w_rd_mux = r_err_rx;
            ADDR_LAST_ERR_EXP: w_rd_mux = r_err_exp;
            default:           w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else if (avalonmm_read) begin
            r_readdata <= w_rd_mux;
        end
    end

    assign avalonmm_readdata = r_readdata;

endmodule
